fetch_prefetch_queue: RTL

- Parametrised instruction-fetch front end for the pipelined CPU.
- Replaces the single-entry fetch stage with a PC generator that issues reads to instruction memory and a DEPTH-entry prefetch queue of {pc, instr} pairs.
- Feeds the rfread stage through a valid/ready handshake.
- Supports flush-and-redirect on jumps and a halt input; fetch continues while downstream is stalled, up to queue capacity.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_ring_buf.sv | 64 ++++++
 rtl/fetch_prefetch_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the prefetch queue entry layout.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PC_INC = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ring_buf.sv
// Power-of-two ring buffer holding fetched entries; flush wins over push/pop.
module fetch_ring_buf #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [31:0],
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  entry_t           i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output entry_t           o_head,
    output logic [CNT_W-1:0] o_count
);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: PC generator with credit-based issue into a prefetch queue.
module fetch_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_INC   = cpu_pkg::PC_INC,
    parameter int unsigned RESET_PC = 0,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_pc_addr,
    output logic              o_pc_rd,
    input  logic [DATA_W-1:0] i_pc_rddata,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    input  logic              i_halt,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_count
);

    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    always_comb begin
        pop = o_valid && i_ready && !i_redirect;
        // Reserve a slot for the outstanding response so a capture can never overflow.
        occupancy = {1'b0, o_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        issue     = !reset && !i_halt && !i_redirect && (occupancy < (CNT_W + 1)'(DEPTH));

        pc_next_d     = pc_next_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (i_redirect) begin
            pc_next_d = i_redirect_addr;
        end else if (issue) begin
            pc_next_d     = pc_next_q + ADDR_W'(PC_INC);
            inflight_pc_d = pc_next_q;
        end

        push_entry.pc    = inflight_pc_q;
        push_entry.instr = i_pc_rddata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_next_q     <= ADDR_W'(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_next_q     <= pc_next_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_ring_buf #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_ring_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (inflight_q),
        .i_data  (push_entry),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_head  (head),
        .o_count (o_count)
    );

    assign o_pc_addr = pc_next_q;
    assign o_pc_rd   = issue;
    assign o_valid   = (o_count != '0);
    assign o_instr   = head.instr;
    assign o_pc      = head.pc;

endmodule
